shift_cmd_buffer: RTL and testbench
===================================

SHIFT_CMD_BUFFER -- requirements
Module: shift_cmd_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data operand width.
REQ-002 SHALL have parameter SHIFTWIDTH, default 5, shift-amount width.
REQ-003 SHALL have parameter DEPTH, default 4, power of two, at least 2, command entries.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port flush, input, 1, synchronous discard of all stored commands.
REQ-007 SHALL have port in_valid, input, 1, upstream command present.
REQ-008 SHALL have port in_ready, output, 1, buffer accepts command this cycle.
REQ-009 SHALL have port in_din, input, WIDTH, operand to be right-shifted.
REQ-010 SHALL have port in_shift, input, SHIFTWIDTH, right-shift amount.
REQ-011 SHALL have port out_valid, output, 1, command presented to the downstream right barrel shifter.
REQ-012 SHALL have port out_ready, input, 1, downstream consumes the command.
REQ-013 SHALL have port out_din, output, WIDTH, operand driven to the shifter din.
REQ-014 SHALL have port out_shift, output, SHIFTWIDTH, amount driven to the shifter shift.
REQ-015 SHALL have port count, output, clog2(DEPTH)+1, stored entries.

Function
REQ-016 SHALL be a FIFO of {din, shift} pairs, in order, no reordering or modification.
REQ-017 SHALL treat a push as in_valid && in_ready and a pop as out_valid && out_ready.
REQ-018 SHALL drive in_ready = (count != DEPTH); when full, in_ready stays 0 even if a pop occurs in the same cycle.
REQ-019 SHALL drive out_valid = (count != 0), subject to REQ-032.
REQ-020 SHALL drive out_din and out_shift from the head entry; they hold stable while out_valid && !out_ready.
REQ-021 SHALL, on simultaneous push and pop with 0 < count < DEPTH, keep count unchanged and advance both pointers.
REQ-022 SHALL use pointers that wrap modulo DEPTH.
REQ-023 SHALL have a minimum latency, from push edge to out_valid, of 1 cycle.
REQ-024 SHALL, on flush, next cycle set count=0 with both pointers at 0 and ignore any same-cycle push; flush has priority over push and pop.
REQ-025 SHALL drive out_din and out_shift to 0 when out_valid=0, never stale data.
REQ-026 SHALL keep count equal at all times to pushes minus pops since the last reset or flush.

Reset
REQ-027 SHALL, on rst asserted, immediately set count=0, pointers=0, out_valid=0, out_din=0, out_shift=0, in_ready=0.
REQ-028 SHALL drive in_ready=1 from the first clock edge after rst deasserts.
REQ-029 SHALL, on rst mid-operation, lose all stored commands with no partial pop visible.
REQ-030 SHALL NOT require storage array contents to reset.

Configuration
REQ-031 SHALL compile a same-cycle bypass path in only when macro SHIFT_CMD_BUFFER_BYPASS_EN is defined.
REQ-032 SHALL, with SHIFT_CMD_BUFFER_BYPASS_EN defined, when count=0, in_valid=1 and flush=0, drive out_valid=1 and out_din/out_shift from in_din/in_shift combinationally; if out_ready=1 the command is not stored and count stays 0.
REQ-033 SHALL, without SHIFT_CMD_BUFFER_BYPASS_EN, have no combinational in-to-out path, with latency per REQ-023.

Structure
REQ-034 SHALL place default WIDTH, SHIFTWIDTH and DEPTH constants and a packed command type {din, shift} in shared package shift_pkg.
REQ-035 SHALL use no sub-module; storage is an internal register array instantiated directly by the top.
REQ-036 SHALL connect out_din/out_shift directly to the right barrel shifter's din/shift in the system top.

Verification
REQ-037 SHALL cover: reset release, then push din=32'hFFFF0000 shift=3 with out_ready=1 -> out_valid at next cycle, out_din=32'hFFFF0000, out_shift=3, shifter output 32'h1FFFE000.
REQ-038 SHALL cover: out_ready=0, push 5 commands -> in_ready=0 after the 4th, count=4, 5th held upstream, the first 4 popped in order.
REQ-039 SHALL cover: count=2, simultaneous push and pop for 10 cycles -> count stays 2 and pointers wrap with no data loss.
REQ-040 SHALL cover: count=3 with flush=1 and in_valid=1 -> next cycle count=0, out_valid=0, out_din=0.
REQ-041 SHALL cover: rst pulsed while count=2 and out_ready=0 -> outputs 0 immediately, and after release the first pop returns the first post-reset command.
REQ-042 SHALL cover, with SHIFT_CMD_BUFFER_BYPASS_EN: empty buffer, push din=32'h00001111 shift=4 with out_ready=1 -> same-cycle out_valid=1, out_din=32'h00001111, count stays 0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared defaults and command type for the shift command buffer.
// The command is the {din, shift} pair later applied to a right barrel shifter.
package shift_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_SHIFTWIDTH = 5;
    localparam int DEF_DEPTH      = 4;

    // One buffered command at default widths: operand plus right-shift amount.
    typedef struct packed {
        logic [DEF_WIDTH-1:0]      din;
        logic [DEF_SHIFTWIDTH-1:0] shift;
    } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_buffer.sv
// shift_cmd_buffer: in-order FIFO of {din, shift} commands feeding a right
// barrel shifter. Storage is a plain register array without reset.
// Optional feature: define SHIFT_CMD_BUFFER_BYPASS_EN to let a command reach
// the outputs in the same cycle when the buffer is empty.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid never depends on ready on the same side; out_din/out_shift hold
// stable while out_valid && !out_ready. in_ready depends only on stored state,
// so a full buffer refuses a push even when a pop happens in the same cycle.
module shift_cmd_buffer
    import shift_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SHIFTWIDTH = DEF_SHIFTWIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_din,
    input  logic [SHIFTWIDTH-1:0]    in_shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_din,
    output logic [SHIFTWIDTH-1:0]    out_shift,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + SHIFTWIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt;
    logic           ready_en;
    logic           stored_valid;
    logic           push;
    logic           bypass_take;
    logic           push_store;
    logic           pop_mem;

    assign stored_valid = (cnt != '0);
    // ready_en keeps in_ready low while rst is held and until the first edge after release.
    assign in_ready     = ready_en && (cnt != FULL_CNT);
    assign push         = in_valid && in_ready;
    assign count        = cnt;

`ifdef SHIFT_CMD_BUFFER_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit  = ready_en && !flush && in_valid && !stored_valid;
    // A bypassed command that is consumed immediately never enters storage.
    assign bypass_take = bypass_hit && out_ready;
`else
    assign bypass_take = 1'b0;
`endif

    // Flush overrides both sides; pointers wrap naturally since DEPTH is a power of two.
    assign push_store = push && !flush && !bypass_take;
    assign pop_mem    = stored_valid && out_ready && !flush;

    // Head presentation: stored head first, optional bypass when empty, zero otherwise.
    always_comb begin
        out_valid = stored_valid;
        out_din   = '0;
        out_shift = '0;
        if (stored_valid) begin
            {out_din, out_shift} = mem[rd_ptr];
        end
`ifdef SHIFT_CMD_BUFFER_BYPASS_EN
        else if (bypass_hit) begin
            out_valid = 1'b1;
            out_din   = in_din;
            out_shift = in_shift;
        end
`endif
    end

    // Enable accepting commands from the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Pointer and occupancy bookkeeping; flush returns to the empty state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_mem) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_store, pop_mem})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Command storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_store) begin
            mem[wr_ptr] <= {in_din, in_shift};
        end
    end

endmodule

// File: tb/tb_shift_cmd_buffer.sv
// Self-checking bench for shift_cmd_buffer. Scoreboard queue holds accepted
// commands; a negedge monitor compares every pop against the queue head.
// Build with SHIFT_CMD_BUFFER_BYPASS_EN defined to exercise the bypass path.
module tb_shift_cmd_buffer;

    localparam int WIDTH = 32;
    localparam int SW    = 5;
    localparam int DEPTH = 4;
    localparam int EW    = WIDTH + SW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_din = '0;
    logic [SW-1:0]     in_shift = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_din;
    logic [SW-1:0]     out_shift;
    logic [2:0]        count;

    int vectors = 0;
    int miscompares = 0;
    logic [EW-1:0] exp_q[$];

    shift_cmd_buffer #(.WIDTH(WIDTH), .SHIFTWIDTH(SW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_din(in_din), .in_shift(in_shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_din(out_din), .out_shift(out_shift),
        .count(count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard monitor: samples mid-cycle, inputs change at posedge+1
    always @(negedge clk) begin
        logic [EW-1:0] exp_v;
        if (rst) begin
            exp_q.delete();
        end else begin
            vectors++;
            if (count !== 3'(exp_q.size())) begin
                miscompares++;
                $display("FAIL count_track: got %0d expected %0d", count, exp_q.size());
            end
            if (!out_valid) begin
                vectors++;
                if (out_din !== '0 || out_shift !== '0) begin
                    miscompares++;
                    $display("FAIL idle_zero: got %h/%0d expected 0/0", out_din, out_shift);
                end
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (in_valid && in_ready) exp_q.push_back({in_din, in_shift});
                if (out_valid && out_ready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL pop_order: got %h/%0d expected no pop", out_din, out_shift);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if ({out_din, out_shift} !== exp_v) begin
                            miscompares++;
                            $display("FAIL pop_order: got %h/%0d expected %h/%0d",
                                     out_din, out_shift, exp_v[EW-1:SW], exp_v[SW-1:0]);
                        end
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [SW-1:0] s,
                         input logic ordy);
        in_valid  = v;
        in_din    = d;
        in_shift  = s;
        out_ready = ordy;
    endtask

    task automatic drain();
        drive(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++) tick();
        out_ready = 1'b0;
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL drain_count: got %0d expected 0", count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || count !== 3'd0 || out_din !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b r=%b c=%0d d=%h expected 0 0 0 0",
                     out_valid, in_ready, count, out_din);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got r=%b v=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 32'hFFFF0000, 5'd3, 1'b1);
`ifdef SHIFT_CMD_BUFFER_BYPASS_EN
        tick();
        drive(1'b0, '0, '0, 1'b1);
`else
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_no_comb: got out_valid=%b expected 0", out_valid);
        end
        tick();
        drive(1'b0, '0, '0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_din !== 32'hFFFF0000 || out_shift !== 5'd3) begin
            miscompares++;
            $display("FAIL single_out: got v=%b %h/%0d expected 1 ffff0000/3",
                     out_valid, out_din, out_shift);
        end
        vectors++;
        if ((out_din >> out_shift) !== 32'h1FFFE000) begin
            miscompares++;
            $display("FAIL single_shifter: got %h expected 1fffe000", out_din >> out_shift);
        end
        tick();
`endif
        vectors++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL single_empty: got v=%b c=%0d expected 0 0", out_valid, count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'b0);
            vectors++;
            if (in_ready !== (i < DEPTH)) begin
                miscompares++;
                $display("FAIL full_ready[%0d]: got %b expected %b", i, in_ready, i < DEPTH);
            end
            tick();
        end
        vectors++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_state: got c=%0d r=%b expected 4 0", count, in_ready);
        end
        // 5th command still waiting upstream; a pop while full does not open in_ready
        out_ready = 1'b1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pop_ready: got %b expected 0", in_ready);
        end
        tick();
        vectors++;
        if (count !== 3'd3 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_after_pop: got c=%0d r=%b expected 3 1", count, in_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_steady();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'b0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'b1);
            tick();
            vectors++;
            if (count !== 3'd2) begin
                miscompares++;
                $display("FAIL steady_count[%0d]: got %0d expected 2", i, count);
            end
        end
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'b0);
            tick();
        end
        flush = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 5'd7, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_din !== '0) begin
            miscompares++;
            $display("FAIL flush_state: got c=%0d v=%b d=%h expected 0 0 0", count, out_valid, out_din);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_din !== '0 || out_shift !== '0 || count !== 3'd0
            || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got v=%b d=%h s=%0d c=%0d r=%b expected all 0",
                     out_valid, out_din, out_shift, count, in_ready);
        end
        @(negedge clk);
        #1 rst = 1'b0;
        tick();
        drive(1'b1, 32'hA5A50F0F, 5'd9, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b1);
`ifndef SHIFT_CMD_BUFFER_BYPASS_EN
        vectors++;
        if (out_valid !== 1'b1 || out_din !== 32'hA5A50F0F || out_shift !== 5'd9) begin
            miscompares++;
            $display("FAIL reset_first_pop: got v=%b %h/%0d expected 1 a5a50f0f/9",
                     out_valid, out_din, out_shift);
        end
`endif
        drain();
    endtask

`ifdef SHIFT_CMD_BUFFER_BYPASS_EN
    task automatic test_bypass();
        drive(1'b1, 32'h00001111, 5'd4, 1'b1);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_din !== 32'h00001111 || out_shift !== 5'd4) begin
            miscompares++;
            $display("FAIL bypass_out: got v=%b %h/%0d expected 1 00001111/4",
                     out_valid, out_din, out_shift);
        end
        tick();
        drive(1'b0, '0, '0, 1'b0);
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL bypass_count: got %0d expected 0", count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full();
        test_steady();
        test_flush();
        test_reset_mid();
`ifdef SHIFT_CMD_BUFFER_BYPASS_EN
        test_bypass();
`endif
        tick();
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL final_queue: got %0d left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
